// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives datapath write enables and mux selects.
// Optional MULTICYCLE_MEM_WAIT_EN adds mem_ready so MEM stretches until memory acknowledges.
//
//   state  | meaning
//   IF     | fetch: load IR
//   ID     | decode; J and NOP retire here
//   EXE_R  | R-type / ADDI ALU op into ALUOut
//   EXE_B  | branch compare, conditional PC update
//   EXE_LS | load/store address into ALUOut
//   MEM    | data memory access
//   WB     | register file write, PC+4
//   HALT   | stopped until reset
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWre,
    output logic       IRWre,
    output logic       ALUOutWre,
    output logic       RegWre,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegDst,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc,
    output logic [2:0] state,
    output logic       halted
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] S_IF     = 3'd0;
    localparam logic [2:0] S_ID     = 3'd1;
    localparam logic [2:0] S_EXE_R  = 3'd2;
    localparam logic [2:0] S_EXE_B  = 3'd3;
    localparam logic [2:0] S_EXE_LS = 3'd4;
    localparam logic [2:0] S_MEM    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [2:0] state_q, state_d;
    logic       mem_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    assign state   = state_q;
    assign ALUSrcA = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUOutWre = 1'b0;
        RegWre    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        RegDst    = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        halted    = 1'b0;

        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = S_EXE_R;
                    OP_LW, OP_SW:      state_d = S_EXE_LS;
                    OP_BEQ:            state_d = S_EXE_B;
                    OP_HALT:           state_d = S_HALT;
                    OP_J: begin
                        PCWre   = 1'b1;
                        PCSrc   = 2'b10;
                        state_d = S_IF;
                    end
                    default: begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_EXE_R: begin
                ALUOutWre = 1'b1;
                if (opcode == OP_RTYPE) begin
                    ALUOp = 3'b010;
                end else begin
                    ALUSrcB = 1'b1;
                end
                state_d = S_WB;
            end
            S_EXE_LS: begin
                ALUSrcB   = 1'b1;
                ALUOutWre = 1'b1;
                state_d   = S_MEM;
            end
            S_EXE_B: begin
                ALUOp   = 3'b001;
                PCWre   = 1'b1;
                PCSrc   = zero ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            S_MEM: begin
                // strobe stays up while waiting; only the ack cycle advances or retires
                if (opcode == OP_SW) begin
                    MemWrite = 1'b1;
                    if (mem_go) begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end
                end else begin
                    MemRead = 1'b1;
                    if (mem_go) begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                RegDst    = (opcode == OP_RTYPE);
                DBDataSrc = (opcode == OP_LW);
                state_d   = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // reset forces every output low, including the IF fetch strobe
        if (!rst_n) begin
            state_d   = S_IF;
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            ALUOutWre = 1'b0;
            RegWre    = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = 3'b000;
            RegDst    = 1'b0;
            DBDataSrc = 1'b0;
            PCSrc     = 2'b00;
            halted    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control state machine for the multicycle CPU. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the write enables of the PC, the instruction register, the ALUOut register, data memory and the register file, plus the datapath mux selects. It sits beside the datapath, takes the opcode from the instruction register and the ALU zero flag, and is the only source of the ALUOut write strobe.

## Interface
- OP_RTYPE, 6'b000000, R-type ALU op (funct decoded downstream)
- OP_ADDI, 6'b000001, add immediate
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_HALT, 6'b111111, halt

Ports:
- clk  in  1  system clock; state register updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- PCWre / IRWre / ALUOutWre / RegWre  out  1 each  write enables
- MemRead / MemWrite  out  1 each  data memory strobes
- ALUSrcA  out  1  0 = rs, 1 = shamt
- ALUSrcB  out  1  0 = rt, 1 = sign-extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 funct-decode
- RegDst  out  1  0 = rt, 1 = rd
- DBDataSrc  out  1  0 = ALUOut, 1 = memory data
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- state  out  3  current state, for debug
- halted  out  1  high in HALT

## Operation
- State encodings: IF=0, ID=1, EXE_R=2, EXE_B=3, EXE_LS=4, MEM=5, WB=6, HALT=7.
- IF: IRWre=1. Next state is ID.
- ID: decode opcode.
  - RTYPE/ADDI go to EXE_R.
  - LW/SW go to EXE_LS.
  - BEQ goes to EXE_B.
  - J: PCWre=1, PCSrc=10, next state IF.
  - HALT goes to HALT.
  - Any other opcode is a NOP: PCWre=1, PCSrc=00, next state IF.
- EXE_R: ALUOutWre=1.
  - RTYPE: ALUOp=010, ALUSrcB=0.
  - ADDI: ALUOp=000, ALUSrcB=1.
  - Next state WB.
- EXE_LS: ALUOp=000, ALUSrcB=1, ALUOutWre=1. Next state MEM.
- EXE_B: ALUOp=001, ALUSrcB=0, PCWre=1, PCSrc = zero ? 01 : 00. Next state IF.
- MEM:
  - LW: MemRead=1, next state WB.
  - SW: MemWrite=1, PCWre=1, PCSrc=00, next state IF.
- WB: RegWre=1, PCWre=1, PCSrc=00, next state IF.
  - RegDst=1 for RTYPE, 0 otherwise.
  - DBDataSrc=1 for LW, 0 otherwise.
- HALT: all enables 0, halted=1. Exit only by reset.
- Outputs are combinational from state and opcode. Any signal not listed for a state is 0.
- opcode is sampled only in ID..WB; it comes from the IR, which is stable after IF.

## Timing
- While rst_n=0: state=IF, and every output is 0, including IRWre, halted and state.
- Reset assert mid-instruction aborts it immediately; no partial write enable stays high.
- After release, the first posedge is in IF with IRWre=1.
- Datapath registers (ALUOut, IR, PC) capture on negedge clk. Controls change after posedge, giving them half a cycle to settle before capture.
- Each write enable is high for exactly one cycle per instruction.
- Cycles per instruction: J=2, BEQ=3, RTYPE/ADDI/SW=4, LW=5, NOP=2.
- zero is sampled only in EXE_B.

## Configuration
- MULTICYCLE_MEM_WAIT_EN defined:
  - Adds input mem_ready (1 bit).
  - MEM holds, with MemRead/MemWrite kept asserted, until mem_ready=1. The transition and the SW PCWre happen only in the cycle mem_ready=1.
  - All other states are unaffected.
- Undefined: there is no mem_ready port and MEM lasts exactly one cycle.

## Test plan
- Reset: rst_n=0 mid-EXE_R → state=0 and all outputs 0 asynchronously. Release → IRWre=1 in the next cycle.
- R-type ADD (opcode 000000): state sequence 0,1,2,6,0. ALUOutWre=1 only in state 2. RegWre=1, RegDst=1, PCWre=1 only in state 6.
- LW (100011) then SW (101011): LW sequence 0,1,4,5,6 with MemRead in 5 and DBDataSrc=1 in 6. SW sequence 0,1,4,5 with MemWrite=1 and PCWre=1 in 5.
- BEQ with zero=1, then BEQ with zero=0: PCSrc=01, then 00. Both have PCWre=1 in state 3 and return to IF after 3 cycles.
- J (000010) → PCSrc=10 and PCWre=1 in ID. Unknown opcode 010101 → PCSrc=00 in ID. HALT (111111) → state 7, halted=1, held for 20 cycles until rst_n=0.
- With MULTICYCLE_MEM_WAIT_EN, LW with mem_ready low for 3 cycles → MEM lasts 4 cycles with MemRead held, then WB.
